hex_digit_scanner: RTL

//  Time-multiplexed scan controller for a multi-digit 7-segment display.

---
 rtl/hex_digit_scanner.sv | 103 ++++++++++
 1 files changed

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Loads go to a shadow register and reach the display only at frame boundaries, so a frame never tears.
module hex_digit_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE      = 50000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic                    A3,
  output logic                    A2,
  output logic                    A1,
  output logic                    A0,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] SEL_DIGIT0 = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] SEL_RESET  = AN_ACTIVE_LOW ? ~SEL_DIGIT0 : SEL_DIGIT0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] active;
  logic [3:0]              nib_q;

  logic                    slot_tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic [3:0]              nib_d;
  logic                    all_zero;

  assign slot_tick = (cnt == CW'(PRESCALE - 1));
  assign wrap      = slot_tick && (idx == IW'(NUM_DIGITS - 1));

  // Blank digit k>0 when it and every more-significant digit of active are zero.
  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so the running all_zero chain is ordered and no latch is inferred.
  always_comb begin
    blank_vec = '0;
    all_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (active[4*k +: 4] == 4'd0);
      blank_vec[k] = (k != 0) && all_zero;
    end
  end

  always_comb begin
    nib_d = 4'd0;
    sel_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k) && !(lz_blank && blank_vec[k])) begin
        nib_d    = active[4*k +: 4];
        sel_d[k] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; shadow/active are plain registers and are reset here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      nib_q      <= 4'd0;
      digit_sel  <= SEL_RESET;
    end else begin
      cnt        <= slot_tick ? '0 : cnt + CW'(1);
      frame_tick <= wrap;
      if (slot_tick) idx <= wrap ? '0 : idx + IW'(1);

      // A load coinciding with the commit bypasses the shadow straight to the display.
      if (wrap && load) begin
        active  <= value_in;
        shadow  <= value_in;
        pending <= 1'b0;
      end else if (wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end

      nib_q     <= nib_d;
      digit_sel <= AN_ACTIVE_LOW ? ~sel_d : sel_d;
    end
  end

  assign {A3, A2, A1, A0} = nib_q;

endmodule
